// File: rtl/timer_ctrl.sv
//------------------------------------------------------------------------------
// timer_ctrl
// Sequencing and control for the 64-bit timer counter: IDLE/RUN/HALT FSM,
// power-of-2 prescaler producing cnt_en, rst_cnt clear strobe, compare-match
// detection with sticky status and interrupt output.
// Optional feature macro: TIMER_DEBUG_HALT_EN (debug HALT state, halt_ack).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_ctrl #(
  parameter int CNT_W   = 64,
  parameter int DIV_W   = 4,
  parameter int MAX_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] cmp,
  input  logic             int_en,
  input  logic             int_st_clr,
  input  logic             halt_req,
  output logic             cnt_en,
  output logic             rst_cnt,
  output logic             int_st,
  output logic             tim_int,
  output logic             halt_ack
);

  localparam int PS_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef TIMER_DEBUG_HALT_EN
    HALT = 2'd2,
`endif
    RUN  = 2'd1
  } state_t;

  state_t            state, state_nxt;
  logic [PS_W-1:0]   int_cnt, int_cnt_nxt;
  logic              div_en_q;
  logic [DIV_W-1:0]  div_val_q;
  logic              chg_q;
  logic              rst_cnt_q;
  logic              int_st_q;

  // Prescaler settings are taken from registered copies so that cnt_en has
  // no combinational path from the register-file inputs.
  logic [DIV_W-1:0]  e_q;
  logic              bypass_q;
  logic [PS_W-1:0]   mask_q;
  logic              wrap;
  logic              cfg_chg;
  logic              active;
  logic              match;

  assign e_q      = (div_val_q > DIV_W'(MAX_DIV)) ? DIV_W'(MAX_DIV) : div_val_q;
  assign bypass_q = !div_en_q || (e_q == '0);
  assign mask_q   = PS_W'(((PS_W+1)'(1) << e_q) - (PS_W+1)'(1));
  assign wrap     = (int_cnt == mask_q);
  assign cfg_chg  = (div_en != div_en_q) || (div_val != div_val_q);
  assign active   = (state != IDLE);
  assign match    = (cnt == cmp);

  // Next-state logic; disabling the timer always wins over a halt request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (timer_en) state_nxt = RUN;
      RUN: begin
        if (!timer_en) state_nxt = IDLE;
`ifdef TIMER_DEBUG_HALT_EN
        else if (halt_req) state_nxt = HALT;
`endif
      end
`ifdef TIMER_DEBUG_HALT_EN
      HALT: begin
        if (!timer_en)     state_nxt = IDLE;
        else if (!halt_req) state_nxt = RUN;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Prescaler count: cleared on disable or settings change, wraps on terminal
  // count; the edge that enters HALT does not advance it, so HALT resumes
  // from the value seen in the last RUN cycle. A change while halted also
  // clears it so a stale count never exceeds the new period.
  always_comb begin
    int_cnt_nxt = int_cnt;
    if (state_nxt == IDLE) begin
      int_cnt_nxt = '0;
    end else if (active && cfg_chg) begin
      int_cnt_nxt = '0;
    end else if ((state == RUN) && !bypass_q) begin
      if (wrap)                    int_cnt_nxt = '0;
      else if (state_nxt == RUN)   int_cnt_nxt = int_cnt + PS_W'(1);
    end
  end

  // State, prescaler and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      int_cnt   <= '0;
      div_en_q  <= 1'b0;
      div_val_q <= '0;
      chg_q     <= 1'b0;
      rst_cnt_q <= 1'b0;
      int_st_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      int_cnt   <= int_cnt_nxt;
      div_en_q  <= div_en;
      div_val_q <= div_val;
      chg_q     <= (state == RUN) && cfg_chg;
      rst_cnt_q <= active && !timer_en;
      int_st_q  <= match | (int_st_q & ~int_st_clr);
    end
  end

  assign cnt_en  = (state == RUN) && !chg_q && (bypass_q || wrap);
  assign rst_cnt = rst_cnt_q;
  assign int_st  = int_st_q;
  assign tim_int = int_st_q & int_en;

`ifdef TIMER_DEBUG_HALT_EN
  assign halt_ack = (state == HALT);
`else
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
  assign halt_ack = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
//------------------------------------------------------------------------------
// tb_timer_ctrl
// Self-checking bench for timer_ctrl: a behavioural model compared every
// cycle plus directed scenarios with hand-computed expectations.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        timer_en, div_en, int_en, int_st_clr, halt_req;
  logic [3:0]  div_val;
  logic [63:0] cnt, cmp;
  logic        cnt_en, rst_cnt, int_st, tim_int, halt_ack;

  int checks   = 0;
  int failures = 0;

  timer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .timer_en(timer_en), .div_en(div_en),
    .div_val(div_val), .cnt(cnt), .cmp(cmp), .int_en(int_en),
    .int_st_clr(int_st_clr), .halt_req(halt_req), .cnt_en(cnt_en),
    .rst_cnt(rst_cnt), .int_st(int_st), .tim_int(tim_int), .halt_ack(halt_ack)
  );

  always #5 clk = ~clk;

  // Counter datapath stand-in
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (rst_cnt) cnt <= '0;
    else if (cnt_en)  cnt <= cnt + 64'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_state: 0 idle, 1 run, 2 halt. m_phase = RUN cycles elapsed in the
  // current prescale period.
  int          m_state, m_phase, m_per, m_nxt;
  bit          m_den, m_chg, m_rst, m_ist, m_changed;
  logic [3:0]  m_dval;

  function automatic int period(input bit den, input logic [3:0] dv);
    int e;
    e = (dv > 4'd8) ? 8 : int'(dv);
    return (!den || e == 0) ? 1 : (1 << e);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_phase = 0; m_den = 0; m_dval = 0;
      m_chg = 0; m_rst = 0; m_ist = 0;
    end else begin
      m_per     = period(m_den, m_dval);
      m_changed = (div_en !== m_den) || (div_val !== m_dval);
      m_nxt     = m_state;
      if (!timer_en)      m_nxt = 0;
      else if (m_state == 0) m_nxt = 1;
`ifdef TIMER_DEBUG_HALT_EN
      else if (halt_req)  m_nxt = 2;
      else                m_nxt = 1;
`endif
      m_rst = (m_state != 0) && !timer_en;
      m_chg = m_changed && (m_state == 1);
      if (m_nxt == 0)                         m_phase = 0;
      else if (m_changed && m_state != 0)     m_phase = 0;
      else if (m_state == 1 && m_per > 1) begin
        if (m_phase == m_per - 1)             m_phase = 0;
        else if (m_nxt == 1)                  m_phase = m_phase + 1;
      end
      m_ist   = (cnt == cmp) ? 1'b1 : (int_st_clr ? 1'b0 : m_ist);
      m_state = m_nxt;
      m_den   = div_en;
      m_dval  = div_val;
    end
  end

  // Compare process: every cycle out of reset
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      m_per = period(m_den, m_dval);
      chk("cnt_en",   cnt_en,   (m_state == 1) && !m_chg && (m_per == 1 || m_phase == m_per - 1));
      chk("rst_cnt",  rst_cnt,  m_rst);
      chk("int_st",   int_st,   m_ist);
      chk("tim_int",  tim_int,  m_ist & int_en);
      chk("halt_ack", halt_ack, m_state == 2);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n, pulses;

  initial begin
    rst_n = 0; timer_en = 0; div_en = 0; div_val = 0; int_en = 0;
    int_st_clr = 0; halt_req = 0; cmp = '1;
    tick(2);
    chk("reset_cnt_en", cnt_en, 0);
    chk("reset_rst_cnt", rst_cnt, 0);
    chk("reset_int_st", int_st, 0);
    chk("reset_tim_int", tim_int, 0);
    chk("reset_halt_ack", halt_ack, 0);
    rst_n = 1;
    tick(1);

    // Bypass count
    timer_en = 1;
    tick(6);
    chk("bypass_cnt5", cnt, 64'h5);
    chk("bypass_cnt_en", cnt_en, 1);

    // Disable
    timer_en = 0;
    tick(1);
    chk("disable_rst_cnt", rst_cnt, 1);
    chk("disable_cnt_en", cnt_en, 0);
    tick(1);
    chk("disable_rst_cnt_once", rst_cnt, 0);
    chk("disable_cnt_clr", cnt, 0);

    // Prescale /4
    div_en = 1; div_val = 4'd2; timer_en = 1;
    tick(1);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (cnt_en) pulses++;
      tick(1);
    end
    chk("prescale4_pulses", pulses, 4);

    // Divisor change 2->3 with int_cnt=2
    tick(2);
    div_val = 4'd3;
    tick(1);
    chk("divchg_suppress", cnt_en, 0);
    n = 1;
    while (!cnt_en && n < 20) begin tick(1); n++; end
    chk("divchg_next_pulse", n, 8);

    // Exponent 12 clamps to 8 -> period 256
    div_val = 4'd12;
    n = 0;
    do begin tick(1); n++; end while (!cnt_en && n < 300);
    chk("clamp_period", n, 256);

    // Interrupt
    timer_en = 0; div_en = 0; div_val = 0;
    tick(2);
    cmp = 64'h10; int_en = 0; timer_en = 1;
    n = 0;
    while (cnt != 64'h10 && n < 40) begin tick(1); n++; end
    chk("irq_cnt_reached", cnt, 64'h10);
    tick(1);
    chk("irq_int_st_set", int_st, 1);
    chk("irq_masked", tim_int, 0);
    int_en = 1;
    #1;
    chk("irq_unmasked", tim_int, 1);
    int_st_clr = 1;
    tick(1);
    int_st_clr = 0;
    chk("irq_cleared", int_st, 0);
    timer_en = 0;
    tick(2);
    cmp = 64'h0;
    tick(1);
    chk("irq_idle_match", int_st, 1);
    int_st_clr = 1;
    tick(1);
    chk("irq_set_wins", int_st, 1);
    cmp = '1;
    tick(1);
    chk("irq_clear_nomatch", int_st, 0);
    int_st_clr = 0; int_en = 0;

    // Halt
    div_en = 1; div_val = 4'd3; timer_en = 1;
    tick(1);
    tick(5);
    halt_req = 1;
    tick(1);
`ifdef TIMER_DEBUG_HALT_EN
    chk("halt_ack", halt_ack, 1);
    chk("halt_cnt_en", cnt_en, 0);
    tick(3);
    halt_req = 0;
    n = 0;
    do begin tick(1); n++; end while (!cnt_en && n < 20);
    chk("halt_resume_pulse", n, 3);
    halt_req = 1;
    tick(1);
    chk("halt_again", halt_ack, 1);
    timer_en = 0;
    tick(1);
    chk("halt_to_idle_ack", halt_ack, 0);
    chk("halt_to_idle_rst", rst_cnt, 1);
    halt_req = 0;
`else
    chk("nohalt_ack", halt_ack, 0);
    n = 1;
    while (!cnt_en && n < 20) begin tick(1); n++; end
    chk("nohalt_pulse", n, 2);
    halt_req = 0;
    timer_en = 0;
`endif
    tick(2);

    // Asynchronous reset mid-operation
    cmp = 64'h0; int_en = 1; div_en = 0; div_val = 0; timer_en = 1;
    tick(3);
    chk("pre_reset_tim_int", tim_int, 1);
    #2 rst_n = 0;
    #1;
    chk("async_cnt_en", cnt_en, 0);
    chk("async_int_st", int_st, 0);
    chk("async_tim_int", tim_int, 0);
    chk("async_rst_cnt", rst_cnt, 0);
    tick(1);
    timer_en = 0; int_en = 0; cmp = '1;
    rst_n = 1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Control and sequencing unit for the 64-bit timer counter. It generates the counter's cnt_en (through a programmable power-of-2 prescaler) and rst_cnt strobes from the timer-enable register bit. It also performs 64-bit compare-match detection with a sticky interrupt status, and handles debug-halt requests. It sits between the register file and the counter datapath.

Parameters:
CNT_W, 64, width of counter value and compare value
DIV_W, 4, width of div_val
MAX_DIV, 8, largest usable divide exponent; prescaler divisor is 2^div_val

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
timer_en  input  1  timer enable (control register bit)
div_en  input  1  prescaler enable
div_val  input  DIV_W  prescaler exponent
cnt  input  CNT_W  current counter value from counter datapath
cmp  input  CNT_W  compare value from register file
int_en  input  1  interrupt enable
int_st_clr  input  1  one-cycle write-1-to-clear pulse for int_st
halt_req  input  1  debug halt request (level)
cnt_en  output  1  increment enable to counter
rst_cnt  output  1  one-cycle counter clear strobe
int_st  output  1  sticky compare-match status
tim_int  output  1  interrupt request to system
halt_ack  output  1  high while in HALT

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. Reset state is IDLE. Prescaler count int_cnt=0, int_st=0, rst_cnt=0, halt_ack=0, cnt_en=0, tim_int=0.
- FSM states: IDLE, RUN, HALT. All transitions occur on the clk rising edge.
  - IDLE->RUN: timer_en=1.
  - RUN->IDLE: timer_en=0.
  - RUN->HALT: halt_req=1 and timer_en=1.
  - HALT->RUN: halt_req=0 and timer_en=1.
  - HALT->IDLE: timer_en=0. This takes priority over halt_req.
- rst_cnt: registered. Pulses high for exactly 1 cycle, in the cycle after timer_en is sampled falling 1->0 in RUN or HALT. The same edge clears int_cnt to 0.
- Effective exponent: e = min(div_val, MAX_DIV). Values 9..15 behave as 8.
- Bypass mode: applies when div_en=0 or e=0. cnt_en = (state==RUN), so the counter advances every cycle.
- Prescale mode:
  - In RUN, int_cnt (8 bits) increments each cycle.
  - cnt_en = (state==RUN) and (int_cnt == 2^e-1).
  - On that cycle int_cnt wraps to 0, giving 1 cnt_en pulse per 2^e RUN cycles.
- cnt_en is combinational from registered state and int_cnt only; there is no combinational path from inputs.
- A change of div_en or div_val while in RUN clears int_cnt to 0 at the next edge. cnt_en is suppressed in the cycle the change is detected.
- HALT: cnt_en=0, int_cnt held, halt_ack=1. On return to RUN, counting resumes from the held int_cnt.
- IDLE: int_cnt held at 0, cnt_en=0.
- Compare:
  - match = (cnt == cmp), full CNT_W-bit equality, evaluated in every state, including IDLE (catches loaded values).
  - int_st is set at the edge after match=1.
  - int_st is sticky until int_st_clr=1.
  - If set and clear occur in the same cycle, set wins and int_st stays 1.
- tim_int = int_st & int_en, combinational. int_st is not gated by int_en.
- Reset mid-operation returns every output to its reset value immediately (asynchronous). No rst_cnt pulse is generated by reset.

Optional Feature:
Macro TIMER_DEBUG_HALT_EN.
- Defined: HALT state and halt_req/halt_ack behave as above.
- Undefined: halt_req is ignored, halt_ack is tied to 0, and the HALT state is not implemented (RUN<->IDLE only). The port list is unchanged.

Test Plan:
- Bypass count: timer_en=1, div_en=0 at edge 0 -> state RUN; cnt_en=1 every cycle from cycle 1; with counter attached, cnt=0x5 after 5 RUN cycles.
- Prescale: div_en=1, div_val=2 -> cnt_en pulses every 4th cycle (int_cnt 0,1,2,3 -> pulse at 3). Set div_val=12 -> pulse every 256 cycles.
- Divisor change: change div_val 2->3 with int_cnt=2 -> int_cnt=0 next cycle, no cnt_en that cycle; next pulse 8 cycles later.
- Disable: timer_en 1->0 in RUN -> rst_cnt=1 for exactly 1 cycle; cnt_en=0; state IDLE.
- Interrupt: cmp=0x10, counter reaches 0x10 -> int_st=1 next cycle; int_en=0 -> tim_int=0; then int_en=1 -> tim_int=1; int_st_clr pulse -> int_st=0. A clear coincident with a new match -> int_st stays 1.
- Halt (macro defined): div_val=3, halt_req=1 at int_cnt=5 -> halt_ack=1, cnt_en=0, int_cnt holds 5. Release -> next cnt_en pulse 2 cycles later. Macro undefined -> halt_req ignored, cnt_en unaffected.
